// File: rtl/core_pkg.sv
// core_pkg: shared core constants and the fetch entry record carried
// through the prefetch FIFO.
package core_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // One buffered fetch result: instruction word, its PC, fault marker.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } fetch_entry_t;

  // Build an entry from its fields.
  function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] instr,
                                              input logic [XLEN-1:0] pc,
                                              input logic            fault);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    e.fault = fault;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries with flush.
// Head entry is presented combinationally; flush wins over push/pop.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  fetch_entry_t              i_push_entry,
  input  logic                      i_pop,
  output fetch_entry_t              o_head,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_pop;

  // A pop on an empty FIFO is ignored so the count can never underflow.
  assign w_pop = i_pop && (r_count != '0);

  // Pointer, count and storage update; entries are cleared on reset so the
  // head reads as zero until the first write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect, feeding a
// prefetch FIFO drained through a valid/ready handshake.
// Optional misaligned-redirect fault marking: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          ADDR_W   = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [31:0]       o_out_instr,
  output logic [31:0]       o_out_pc,
  output logic              o_out_fault
);

  localparam int              CNT_W     = $clog2(DEPTH) + 1;
  localparam int              OCC_W     = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_inflight_pc;
  logic             r_inflight;
  logic [CNT_W-1:0] w_count;
  logic [OCC_W-1:0] w_occupancy;
  logic             w_fault_stall;
  logic             w_inflight_fault;
  logic             w_redirect_misaligned;
  logic             w_push;
  logic             w_pop;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_fault_stall;
  logic r_inflight_fault;

  assign w_redirect_misaligned = (i_redirect_pc[1:0] != 2'b00);
  assign w_fault_stall         = r_fault_stall;
  assign w_inflight_fault      = r_inflight_fault;

  // A misaligned redirect parks fetch and schedules one NOP fault entry
  // for the next edge; any later redirect re-evaluates the stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault_stall    <= 1'b0;
      r_inflight_fault <= 1'b0;
    end else if (i_redirect_valid) begin
      r_fault_stall    <= w_redirect_misaligned;
      r_inflight_fault <= w_redirect_misaligned;
    end else begin
      r_inflight_fault <= 1'b0;
    end
  end

  assign o_out_fault = w_head.fault;
`else
  logic w_unused_fault;

  assign w_redirect_misaligned = 1'b0;
  assign w_fault_stall         = 1'b0;
  assign w_inflight_fault      = 1'b0;
  // The fault bit still travels in the entry but is never set here.
  assign w_unused_fault        = w_head.fault;
  assign o_out_fault           = 1'b0;
`endif

  // Slots already promised: buffered entries plus the response on its way.
  assign w_occupancy = {1'b0, w_count} + OCC_W'(r_inflight);

  // Reset gating keeps the request low while rst_n is asserted.
  assign o_imem_req  = i_rst_n && !w_fault_stall && (w_occupancy < DEPTH_OCC);
  assign o_imem_addr = r_fetch_pc[ADDR_W-1:0];

  // Fetch PC and in-flight tracking; a redirect overrides any issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (i_redirect_valid) begin
      r_fetch_pc    <= i_redirect_pc;
      r_inflight    <= w_redirect_misaligned;
      r_inflight_pc <= i_redirect_pc;
    end else if (o_imem_req) begin
      r_fetch_pc    <= r_fetch_pc + 32'd4;
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fetch_pc;
    end else begin
      r_inflight    <= 1'b0;
    end
  end

  // A response arriving on a redirect edge belongs to the old stream.
  assign w_push       = r_inflight && !i_redirect_valid;
  assign w_pop        = o_out_valid && i_out_ready && !i_redirect_valid;
  assign w_push_entry = make_entry(w_inflight_fault ? NOP_INSTR : i_imem_rdata,
                                   r_inflight_pc, w_inflight_fault);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_redirect_valid),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  assign o_out_valid = (w_count != '0);
  assign o_out_instr = w_head.instr;
  assign o_out_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a 1-cycle memory
// preloaded with word[i] = i. Misalign checks follow FETCH_MISALIGN_CHECK_EN.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  logic [31:0] mem [4096];
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h8000_0000),
    .ADDR_W   (14)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_req       (imem_req),
    .o_imem_addr      (imem_addr),
    .i_imem_rdata     (imem_rdata),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_out_valid      (out_valid),
    .i_out_ready      (out_ready),
    .o_out_instr      (out_instr),
    .o_out_pc         (out_pc),
    .o_out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, fixed one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr[13:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[%0t] FAIL %s: got %h expected %h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s = %h", $time, tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input logic ready);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = ready;
    rst_n          = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int reqs;
    for (int i = 0; i < 4096; i++) mem[i] = i;

    // ---- reset state and streaming from reset ----
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    rst_n          = 1'b0;
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc",    out_pc,         32'd0);
    check("rst_instr", out_instr,      32'd0);
    check("rst_fault", 32'(out_fault), 32'd0);
    check("rst_req",   32'(imem_req),  32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_req",  32'(imem_req),  32'd1);
    check("rel_addr", 32'(imem_addr), 32'h0);
    step();
    check("e1_valid", 32'(out_valid), 32'd0);
    check("e1_addr",  32'(imem_addr), 32'h4);
    for (int k = 0; k < 8; k++) begin
      step();
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_pc",    out_pc,         BASE + 32'(4 * k));
      check("seq_instr", out_instr,      32'(k));
      check("seq_addr",  32'(imem_addr), 32'(4 * (k + 2)));
    end

    // ---- back-pressure: fill, stall, then drain without gaps ----
    hold_reset(1'b0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) reqs++;
      step();
    end
    check("full_reqs",  32'(reqs),      32'd4);
    check("full_req",   32'(imem_req),  32'd0);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_pc",    out_pc,         BASE);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("drain_valid", 32'(out_valid), 32'd1);
      check("drain_pc",    out_pc,         BASE + 32'(4 * (i + 1)));
      check("drain_instr", out_instr,      32'(i + 1));
    end

    // ---- redirect with 3 buffered entries and one in flight ----
    hold_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    check("pre_redir_pc", out_pc, BASE);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("redir_e0_valid", 32'(out_valid), 32'd0);
    check("redir_e0_req",   32'(imem_req),  32'd1);
    check("redir_e0_addr",  32'(imem_addr), 32'h100);
    out_ready = 1'b1;
    step();
    check("redir_e1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("redir_valid", 32'(out_valid), 32'd1);
      check("redir_pc",    out_pc,         32'h8000_0100 + 32'(4 * i));
      check("redir_instr", out_instr,      32'h40 + 32'(i));
    end

    // ---- back-to-back redirects while popping: last one wins ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    step();
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("b2b_e0_valid", 32'(out_valid), 32'd0);
    step();
    check("b2b_e1_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_pc",    out_pc,         32'h8000_0200 + 32'(4 * i));
      check("b2b_instr", out_instr,      32'h80 + 32'(i));
    end

    // ---- asynchronous reset pulse between edges ----
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_req",   32'(imem_req),  32'd0);
    check("arst_pc",    out_pc,         32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("arel_req",  32'(imem_req),  32'd1);
    check("arel_addr", 32'(imem_addr), 32'h0);
    step();
    check("arel_e1_valid", 32'(out_valid), 32'd0);
    step();
    check("arel_e2_valid", 32'(out_valid), 32'd1);
    check("arel_e2_pc",    out_pc,         BASE);
    check("arel_e2_instr", out_instr,      32'd0);

    // ---- misaligned redirect ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis_e0_req", 32'(imem_req), 32'd0);
    step();
    check("mis_valid", 32'(out_valid), 32'd1);
    check("mis_fault", 32'(out_fault), 32'd1);
    check("mis_pc",    out_pc,         32'h8000_0102);
    check("mis_instr", out_instr,      32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mis_stall_valid", 32'(out_valid), 32'd0);
      check("mis_stall_req",   32'(imem_req),  32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("mis_clr_req", 32'(imem_req), 32'd1);
    step();
    step();
    check("mis_clr_valid", 32'(out_valid), 32'd1);
    check("mis_clr_pc",    out_pc,         32'h8000_0200);
    check("mis_clr_fault", 32'(out_fault), 32'd0);
`else
    check("mis_e0_req",  32'(imem_req),  32'd1);
    check("mis_e0_addr", 32'(imem_addr), 32'h102);
    step();
    step();
    check("mis_valid", 32'(out_valid), 32'd1);
    check("mis_fault", 32'(out_fault), 32'd0);
    check("mis_pc",    out_pc,         32'h8000_0102);
    check("mis_instr", out_instr,      32'h40);
    step();
    check("mis_next_pc",    out_pc,         32'h8000_0106);
    check("mis_next_instr", out_instr,      32'h41);
    check("mis_next_fault", 32'(out_fault), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
